// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin line arbiter.
// Latency: n/a (types and combinational helper only).
// Backpressure: n/a.
//
// Contents:
//   arb_state_t  - two-state arbiter FSM encoding
//   first_from() - wrapped priority scan starting at a rotating pointer
package arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // The scan helper works on a fixed maximum width so one function serves
    // every arbiter size; callers zero-extend their request vector. Arbiters
    // wider than ARB_MAX_REQ requesters are not supported.
    localparam int ARB_MAX_N   = 5;
    localparam int ARB_MAX_REQ = 1 << ARB_MAX_N;

    // Returns the index of the first set bit of req, scanning upward from
    // ptr and wrapping modulo n_req. Returns -1 when no bit in range is set.
    // Requires ptr < n_req, so one subtraction is enough for the wrap.
    function automatic int first_from(input logic [ARB_MAX_REQ-1:0] req,
                                      input int                     n_req,
                                      input int                     ptr);
        int win;
        int idx;
        win = -1;
        for (int i = 0; i < ARB_MAX_REQ; i++) begin
            idx = ptr + i;
            if (idx >= n_req) begin
                idx = idx - n_req;
            end
            // i < n_req keeps the scan to one lap; later laps may alias.
            if ((win < 0) && (i < n_req) && req[idx[ARB_MAX_N-1:0]]) begin
                win = idx;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/line_decoder.sv
// Binary code to one-hot line decoder.
// Latency: combinational, zero cycles.
// Backpressure: none; output follows the code input.
//
// Ports:
//   code  in   WIDTH        binary index
//   line  out  2**WIDTH     one-hot image of code (exactly one bit set)
module line_decoder #(
    parameter int WIDTH = 2
) (
    input  logic [WIDTH-1:0]        code,
    output logic [(1<<WIDTH)-1:0]   line
);

    always_comb begin
        line       = '0;
        line[code] = 1'b1;
    end

endmodule

// File: rtl/rr_line_arbiter.sv
// Round-robin arbiter sharing one resource among 2**N level-sensitive requesters.
// Latency: one cycle from req to grant; all outputs come from registers.
// Backpressure: a grant holds while its req stays high, capped at MAX_HOLD cycles; no preemption.
//
// Ports:
//   clk          in   1      rising-edge clock
//   rst_n        in   1      asynchronous active-low reset
//   req          in   2**N   request per requester
//   grant_valid  out  1      a grant is active this cycle
//   grant_code   out  N      index of the granted requester (0 when idle)
//   grant_line   out  2**N   one-hot grant, all zero when grant_valid is low
module rr_line_arbiter
    import arb_pkg::*;
#(
    parameter int N        = 2,
    parameter int MAX_HOLD = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [(1<<N)-1:0]   req,
    output logic                grant_valid,
    output logic [N-1:0]        grant_code,
    output logic [(1<<N)-1:0]   grant_line
);

    localparam int NREQ = 1 << N;
    localparam int HW   = $clog2(MAX_HOLD + 1);

    // Registered state
    arb_state_t       state;
    logic [N-1:0]     ptr;
    logic [HW-1:0]    hold_cnt;

    // Next-state values
    arb_state_t       state_nxt;
    logic [N-1:0]     ptr_nxt;
    logic [HW-1:0]    hold_nxt;
    logic [N-1:0]     code_nxt;
    logic             valid_nxt;

    // Arbitration helpers
    logic [NREQ-1:0]  masked_req;
    logic             release_now;
    int               win;

    logic [NREQ-1:0]  dec_line;

    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        hold_nxt    = hold_cnt;
        code_nxt    = grant_code;
        valid_nxt   = grant_valid;
        masked_req  = req;
        release_now = 1'b0;
        win         = -1;

        case (state)
            IDLE: begin
                win = first_from(ARB_MAX_REQ'(req), NREQ, int'(ptr));
                if (win >= 0) begin
                    state_nxt = GRANT;
                    code_nxt  = N'(win);
                    valid_nxt = 1'b1;
                    hold_nxt  = HW'(1);
                end
            end

            GRANT: begin
                release_now = !req[grant_code] || (hold_cnt == HW'(MAX_HOLD));
                if (!release_now) begin
                    hold_nxt = hold_cnt + HW'(1);
                end else begin
                    // Pointer moves past the releasing requester; N-bit add wraps.
                    ptr_nxt = grant_code + N'(1);
                    // The releaser sits out this one arbitration. On a normal
                    // release its req is already low, so masking only matters
                    // on timeout, where it forces a handover or an idle cycle.
                    masked_req[grant_code] = 1'b0;
                    win = first_from(ARB_MAX_REQ'(masked_req), NREQ, int'(ptr_nxt));
                    if (win >= 0) begin
                        state_nxt = GRANT;
                        code_nxt  = N'(win);
                        valid_nxt = 1'b1;
                        hold_nxt  = HW'(1);
                    end else begin
                        state_nxt = IDLE;
                        code_nxt  = '0;
                        valid_nxt = 1'b0;
                        hold_nxt  = '0;
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
                code_nxt  = '0;
                valid_nxt = 1'b0;
                hold_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= '0;
            hold_cnt    <= '0;
            grant_code  <= '0;
            grant_valid <= 1'b0;
        end else begin
            state       <= state_nxt;
            ptr         <= ptr_nxt;
            hold_cnt    <= hold_nxt;
            grant_code  <= code_nxt;
            grant_valid <= valid_nxt;
        end
    end

    line_decoder #(
        .WIDTH (N)
    ) u_line_decoder (
        .code  (grant_code),
        .line  (dec_line)
    );

    // Decoded from registered code and gated by the registered valid, so
    // grant_line has no combinational path from req.
    assign grant_line = dec_line & {NREQ{grant_valid}};

endmodule

// File: tb/tb_rr_line_arbiter.sv
module tb_rr_line_arbiter;

    localparam int N    = 2;
    localparam int MH   = 4;
    localparam int NREQ = 1 << N;

    logic             clk;
    logic             rst_n;
    logic [NREQ-1:0]  req;
    logic             grant_valid;
    logic [N-1:0]     grant_code;
    logic [NREQ-1:0]  grant_line;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int m_valid;
    int m_code;
    int m_cnt;
    int m_ptr;

    typedef struct {
        logic [3:0] req;
        logic       vld;
        logic [1:0] code;
        logic [3:0] line;
    } vec_t;

    vec_t tbl[24];

    rr_line_arbiter #(
        .N        (N),
        .MAX_HOLD (MH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .grant_valid (grant_valid),
        .grant_code  (grant_code),
        .grant_line  (grant_line)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 0;
        m_code  = 0;
        m_cnt   = 0;
        m_ptr   = 0;
    endtask

    // One clock edge of the arbitration rules, applied to the sampled req.
    task automatic model_step(input logic [3:0] r);
        int excl;
        excl = -1;
        if (m_valid != 0 && r[m_code[1:0]] && m_cnt < MH) begin
            m_cnt++;
            return;
        end
        if (m_valid != 0) begin
            excl  = m_code;
            m_ptr = (m_code + 1) % NREQ;
        end
        m_valid = 0;
        m_code  = 0;
        m_cnt   = 0;
        for (int k = 0; k < NREQ; k++) begin
            int c;
            c = (m_ptr + k) % NREQ;
            if (c != excl && r[c[1:0]]) begin
                m_valid = 1;
                m_code  = c;
                m_cnt   = 1;
                break;
            end
        end
    endtask

    task automatic compare_model();
        check("model_valid", 32'(grant_valid), m_valid);
        check("model_code",  32'(grant_code),  m_code);
        check("model_line",  32'(grant_line),  (m_valid != 0) ? (1 << m_code) : 0);
    endtask

    // Apply req away from the edge, clock it in, then sample at the falling edge.
    task automatic step(input logic [3:0] r);
        req = r;
        @(posedge clk);
        model_step(r);
        @(negedge clk);
    endtask

    // Structural properties checked every cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            check("onehot0_line", 32'($onehot0(grant_line)), 32'd1);
            if (grant_valid) begin
                check("line_vs_code", 32'(grant_line), 32'(4'b0001 << grant_code));
            end
        end
    end

    initial begin
        logic [3:0] cur;

        tbl[0]  = '{4'b1111, 1'b1, 2'd0, 4'b0001};
        tbl[1]  = '{4'b1111, 1'b1, 2'd0, 4'b0001};
        tbl[2]  = '{4'b1110, 1'b1, 2'd1, 4'b0010};
        tbl[3]  = '{4'b1110, 1'b1, 2'd1, 4'b0010};
        tbl[4]  = '{4'b1100, 1'b1, 2'd2, 4'b0100};
        tbl[5]  = '{4'b1100, 1'b1, 2'd2, 4'b0100};
        tbl[6]  = '{4'b1000, 1'b1, 2'd3, 4'b1000};
        tbl[7]  = '{4'b1000, 1'b1, 2'd3, 4'b1000};
        tbl[8]  = '{4'b0000, 1'b0, 2'd0, 4'b0000};
        tbl[9]  = '{4'b0001, 1'b1, 2'd0, 4'b0001};
        tbl[10] = '{4'b0001, 1'b1, 2'd0, 4'b0001};
        tbl[11] = '{4'b0001, 1'b1, 2'd0, 4'b0001};
        tbl[12] = '{4'b0001, 1'b1, 2'd0, 4'b0001};
        tbl[13] = '{4'b0001, 1'b0, 2'd0, 4'b0000};
        tbl[14] = '{4'b0001, 1'b1, 2'd0, 4'b0001};
        tbl[15] = '{4'b0000, 1'b0, 2'd0, 4'b0000};
        tbl[16] = '{4'b0100, 1'b1, 2'd2, 4'b0100};
        tbl[17] = '{4'b0101, 1'b1, 2'd2, 4'b0100};
        tbl[18] = '{4'b0101, 1'b1, 2'd2, 4'b0100};
        tbl[19] = '{4'b0101, 1'b1, 2'd2, 4'b0100};
        tbl[20] = '{4'b0101, 1'b1, 2'd0, 4'b0001};
        tbl[21] = '{4'b0011, 1'b1, 2'd0, 4'b0001};
        tbl[22] = '{4'b0010, 1'b1, 2'd1, 4'b0010};
        tbl[23] = '{4'b0000, 1'b0, 2'd0, 4'b0000};

        // Reset with every requester active: outputs must stay cleared.
        rst_n = 1'b0;
        req   = 4'b1111;
        model_reset();
        #3;
        check("rst_valid", 32'(grant_valid), 32'd0);
        check("rst_code",  32'(grant_code),  32'd0);
        check("rst_line",  32'(grant_line),  32'd0);
        @(posedge clk);
        @(negedge clk);
        check("rst_edge_valid", 32'(grant_valid), 32'd0);
        rst_n = 1'b1;

        // Directed sequences: release order, timeout, wrap, handover.
        for (int i = 0; i < 24; i++) begin
            step(tbl[i].req);
            check($sformatf("tbl%0d_valid", i), 32'(grant_valid), 32'(tbl[i].vld));
            check($sformatf("tbl%0d_code", i),  32'(grant_code),  32'(tbl[i].code));
            check($sformatf("tbl%0d_line", i),  32'(grant_line),  32'(tbl[i].line));
            compare_model();
        end

        // Asynchronous reset in the middle of a grant to requester 2.
        step(4'b0100);
        check("pre_rst_code", 32'(grant_code), 32'd2);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(grant_valid), 32'd0);
        check("async_rst_line",  32'(grant_line),  32'd0);
        check("async_rst_code",  32'(grant_code),  32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(4'b1111);
        check("post_rst_code", 32'(grant_code), 32'd0);
        check("post_rst_line", 32'(grant_line), 32'd1);
        compare_model();

        // Randomized traffic; requests tend to persist so timeouts occur.
        cur = 4'b0000;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) < 3) begin
                cur = 4'($urandom_range(0, 15));
            end
            step(cur);
            compare_model();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
